// File: rtl/mips_datapath_pc_predict_pkg.sv
// Shared types for the fetch-stage PC predictor: control bundle and resolved-instruction kinds.
package mips_datapath_pc_predict_pkg;

    typedef enum logic [1:0] {
        KindBranch = 2'd0,
        KindJump   = 2'd1,
        KindCall   = 2'd2,
        KindReturn = 2'd3
    } pc_kind_e;

    typedef struct packed {
        logic clk;
        logic rst_n;
    } ctrl_t;

endpackage

// File: rtl/mips_datapath_pc_predict_btb.sv
// Direct-mapped branch target buffer: combinational lookup, saturating-counter training.
// The kind output exists only when MIPS_DATAPATH_PC_PREDICT_RAS_EN is defined.
module mips_datapath_pc_predict_btb
    import mips_datapath_pc_predict_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned STEP      = 4,
    parameter int unsigned BTB_DEPTH = 16,
    parameter int unsigned TAG_W     = 8,
    parameter int unsigned CTR_W     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic              taken,
    output logic [ADDR_W-1:0] target,
`ifdef MIPS_DATAPATH_PC_PREDICT_RAS_EN
    output pc_kind_e          kind,
`endif
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  pc_kind_e          upd_kind
);

    localparam int unsigned SKIP  = $clog2(STEP);
    localparam int unsigned IDX_W = $clog2(BTB_DEPTH);

    localparam logic [CTR_W-1:0] CtrMax  = '1;
    localparam logic [CTR_W-1:0] CtrWeak = CtrMax ^ (CtrMax >> 1);

    logic [BTB_DEPTH-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q    [BTB_DEPTH];
    logic [TAG_W-1:0]     tag_d    [BTB_DEPTH];
    logic [ADDR_W-1:0]    target_q [BTB_DEPTH];
    logic [ADDR_W-1:0]    target_d [BTB_DEPTH];
    pc_kind_e             kind_q   [BTB_DEPTH];
    pc_kind_e             kind_d   [BTB_DEPTH];
    logic [CTR_W-1:0]     ctr_q    [BTB_DEPTH];
    logic [CTR_W-1:0]     ctr_d    [BTB_DEPTH];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             up_hit;

    // Only the index and tag fields of either address take part in lookup.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{lookup_addr, upd_pc};

    always_comb begin
        lk_idx = lookup_addr[SKIP +: IDX_W];
        lk_tag = lookup_addr[SKIP + IDX_W +: TAG_W];
        hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        taken  = hit && ((kind_q[lk_idx] != KindBranch) || ctr_q[lk_idx][CTR_W-1]);
        target = target_q[lk_idx];
    end

`ifdef MIPS_DATAPATH_PC_PREDICT_RAS_EN
    assign kind = kind_q[lk_idx];
`endif

    always_comb begin
        up_idx   = upd_pc[SKIP +: IDX_W];
        up_tag   = upd_pc[SKIP + IDX_W +: TAG_W];
        up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        kind_d   = kind_q;
        ctr_d    = ctr_q;
        if (upd_valid) begin
            if (up_hit) begin
                target_d[up_idx] = upd_target;
                kind_d[up_idx]   = upd_kind;
                if (upd_taken) begin
                    if (ctr_q[up_idx] != CtrMax) ctr_d[up_idx] = ctr_q[up_idx] + CTR_W'(1);
                end else begin
                    if (ctr_q[up_idx] != '0) ctr_d[up_idx] = ctr_q[up_idx] - CTR_W'(1);
                end
            end else if (upd_taken) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = upd_target;
                kind_d[up_idx]   = upd_kind;
                ctr_d[up_idx]    = CtrWeak;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload needs no reset; valid bits gate every use of it.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
        kind_q   <= kind_d;
        ctr_q    <= ctr_d;
    end

endmodule

// File: rtl/mips_datapath_pc_predict.sv
// Fetch PC generator with stall, redirect and BTB prediction.
// Optional return address stack enabled by MIPS_DATAPATH_PC_PREDICT_RAS_EN.
module mips_datapath_pc_predict
    import mips_datapath_pc_predict_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       STEP      = 4,
    parameter logic [ADDR_W-1:0] RESET     = 'h400000,
    parameter int unsigned       BTB_DEPTH = 16,
    parameter int unsigned       TAG_W     = 8,
    parameter int unsigned       CTR_W     = 2,
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  ctrl_t             ctrl,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  pc_kind_e          upd_kind,
    output logic [ADDR_W-1:0] addr_curr,
    output logic [ADDR_W-1:0] addr_next,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target
);

    localparam logic [ADDR_W-1:0] StepAddr = ADDR_W'(STEP);

    logic [ADDR_W-1:0] pc_q;
    logic              btb_hit;
    logic              btb_taken;
    logic [ADDR_W-1:0] btb_target;
`ifdef MIPS_DATAPATH_PC_PREDICT_RAS_EN
    pc_kind_e          btb_kind;
`endif

    mips_datapath_pc_predict_btb #(
        .ADDR_W    (ADDR_W),
        .STEP      (STEP),
        .BTB_DEPTH (BTB_DEPTH),
        .TAG_W     (TAG_W),
        .CTR_W     (CTR_W)
    ) u_btb (
        .clk         (ctrl.clk),
        .rst_n       (ctrl.rst_n),
        .lookup_addr (pc_q),
        .hit         (btb_hit),
        .taken       (btb_taken),
        .target      (btb_target),
`ifdef MIPS_DATAPATH_PC_PREDICT_RAS_EN
        .kind        (btb_kind),
`endif
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .upd_kind    (upd_kind)
    );

`ifdef MIPS_DATAPATH_PC_PREDICT_RAS_EN
    localparam int unsigned       RAS_IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [RAS_IDX_W:0] RasFull  = (RAS_IDX_W + 1)'(RAS_DEPTH);
    localparam logic [ADDR_W-1:0] RetOffset = ADDR_W'(2 * STEP);

    logic [ADDR_W-1:0]    ras_q [RAS_DEPTH];
    logic [RAS_IDX_W-1:0] ras_ptr_q, ras_ptr_d, ras_wr_ptr;
    logic [RAS_IDX_W:0]   ras_cnt_q, ras_cnt_d;
    logic                 ras_active, ras_use, ras_push, ras_pop;

    // Speculative stack: redirects never repair it, and a full push overwrites the oldest.
    always_comb begin
        ras_active = !stall && !redirect;
        ras_use    = btb_hit && (btb_kind == KindReturn) && (ras_cnt_q != '0);
        ras_push   = ras_active && btb_taken && (btb_kind == KindCall);
        ras_pop    = ras_active && ras_use;
        ras_wr_ptr = ras_ptr_q + RAS_IDX_W'(1);
        ras_ptr_d  = ras_ptr_q;
        ras_cnt_d  = ras_cnt_q;
        if (ras_push) begin
            ras_ptr_d = ras_wr_ptr;
            if (ras_cnt_q != RasFull) ras_cnt_d = ras_cnt_q + (RAS_IDX_W + 1)'(1);
        end else if (ras_pop) begin
            ras_ptr_d = ras_ptr_q - RAS_IDX_W'(1);
            ras_cnt_d = ras_cnt_q - (RAS_IDX_W + 1)'(1);
        end
        pred_target = ras_use ? ras_q[ras_ptr_q] : btb_target;
    end

    always_ff @(posedge ctrl.clk) begin
        if (!ctrl.rst_n) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end

    always_ff @(posedge ctrl.clk) begin
        if (ras_push) ras_q[ras_wr_ptr] <= pc_q + RetOffset;
    end
`else
    assign pred_target = btb_target;
`endif

    assign pred_taken = btb_taken;
    assign addr_curr  = pc_q;

    always_comb begin
        if (!ctrl.rst_n) begin
            addr_next = RESET;
        end else if (redirect) begin
            addr_next = redirect_addr;
        end else if (stall) begin
            addr_next = pc_q;
        end else if (pred_taken) begin
            addr_next = pred_target;
        end else begin
            addr_next = pc_q + StepAddr;
        end
    end

    always_ff @(posedge ctrl.clk) begin
        if (!ctrl.rst_n) begin
            pc_q <= RESET;
        end else begin
            pc_q <= addr_next;
        end
    end

endmodule

// File: tb/tb_mips_datapath_pc_predict.sv
// Directed bench for mips_datapath_pc_predict; RAS steps run when MIPS_DATAPATH_PC_PREDICT_RAS_EN is set.
module tb_mips_datapath_pc_predict;
    import mips_datapath_pc_predict_pkg::*;

    logic        clk;
    logic        rst_n;
    ctrl_t       ctrl;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    pc_kind_e    upd_kind;
    logic [31:0] addr_curr;
    logic [31:0] addr_next;
    logic        pred_taken;
    logic [31:0] pred_target;

    int total;
    int bad;

    assign ctrl = '{clk: clk, rst_n: rst_n};

    mips_datapath_pc_predict dut (
        .ctrl          (ctrl),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .upd_kind      (upd_kind),
        .addr_curr     (addr_curr),
        .addr_next     (addr_next),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic go_to(input logic [31:0] a);
        redirect      = 1'b1;
        redirect_addr = a;
        step();
        redirect      = 1'b0;
        settle();
    endtask

    task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input pc_kind_e k);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tgt;
        upd_kind   = k;
        step();
        upd_valid  = 1'b0;
    endtask

`ifdef MIPS_DATAPATH_PC_PREDICT_RAS_EN
    logic [31:0] calls [5];
    logic [31:0] pops  [5];
`endif

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        stall         = 1'b0;
        redirect      = 1'b0;
        redirect_addr = '0;
        upd_valid     = 1'b0;
        upd_pc        = '0;
        upd_taken     = 1'b0;
        upd_target    = '0;
        upd_kind      = KindBranch;

        // Reset and sequential fetch
        step();
        step();
        check("rst_addr_next", addr_next, 32'h0040_0000);
        check("rst_addr_curr", addr_curr, 32'h0040_0000);
        rst_n = 1'b1;
        settle();
        check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        check("seq_next0", addr_next, 32'h0040_0004);
        step();
        check("seq_curr1", addr_curr, 32'h0040_0004);
        step();
        check("seq_curr2", addr_curr, 32'h0040_0008);

        // Stall holds; redirect beats stall
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold", addr_curr, 32'h0040_0008);
        end
        redirect      = 1'b1;
        redirect_addr = 32'h0040_0100;
        settle();
        check("redir_over_stall_next", addr_next, 32'h0040_0100);
        step();
        redirect = 1'b0;
        stall    = 1'b0;
        check("redir_over_stall_curr", addr_curr, 32'h0040_0100);

        // Taken branch allocates weakly taken
        train(32'h0040_0010, 1'b1, 32'h0040_0080, KindBranch);
        go_to(32'h0040_0010);
        check("br_pred_taken", {31'd0, pred_taken}, 32'd1);
        check("br_pred_target", pred_target, 32'h0040_0080);
        check("br_addr_next", addr_next, 32'h0040_0080);

        // Not-taken training: lookup sees old contents, then ctr 2->1->0->0
        stall      = 1'b1;
        upd_valid  = 1'b1;
        upd_pc     = 32'h0040_0010;
        upd_taken  = 1'b0;
        upd_target = 32'h0040_0080;
        upd_kind   = KindBranch;
        settle();
        check("same_cycle_old_view", {31'd0, pred_taken}, 32'd1);
        step();
        check("ctr1_not_taken", {31'd0, pred_taken}, 32'd0);
        step();
        step();
        check("ctr_sat0_not_taken", {31'd0, pred_taken}, 32'd0);
        upd_valid = 1'b0;
        stall     = 1'b0;
        settle();
        check("ctr0_seq_next", addr_next, 32'h0040_0014);

        // Upper saturation: four taken then one not-taken still predicts taken
        stall     = 1'b1;
        upd_valid = 1'b1;
        upd_taken = 1'b1;
        for (int i = 0; i < 4; i++) step();
        upd_taken = 1'b0;
        step();
        check("ctr_sat3_minus1", {31'd0, pred_taken}, 32'd1);
        step();
        check("ctr_1_not_taken", {31'd0, pred_taken}, 32'd0);
        upd_valid = 1'b0;
        stall     = 1'b0;

        // Alias: same index, different tag misses
        go_to(32'h0040_0050);
        check("alias_miss", {31'd0, pred_taken}, 32'd0);
        check("alias_seq_next", addr_next, 32'h0040_0054);
        stall = 1'b1;
        train(32'h0040_0050, 1'b0, 32'h0040_0999, KindBranch);
        settle();
        check("miss_not_taken_no_alloc", {31'd0, pred_taken}, 32'd0);
        stall = 1'b0;

        // Jump trained in a redirect cycle; counter does not gate non-branches
        redirect      = 1'b1;
        redirect_addr = 32'h0040_0030;
        train(32'h0040_0030, 1'b1, 32'h0040_0200, KindJump);
        redirect = 1'b0;
        settle();
        check("jump_pred_taken", {31'd0, pred_taken}, 32'd1);
        check("jump_addr_next", addr_next, 32'h0040_0200);
        stall = 1'b1;
        train(32'h0040_0030, 1'b0, 32'h0040_0200, KindJump);
        train(32'h0040_0030, 1'b0, 32'h0040_0200, KindJump);
        settle();
        check("jump_ctr0_taken", {31'd0, pred_taken}, 32'd1);
        check("jump_target", pred_target, 32'h0040_0200);
        stall = 1'b0;

        // Address wrap
        go_to(32'hFFFF_FFFC);
        check("wrap_curr", addr_curr, 32'hFFFF_FFFC);
        check("wrap_next", addr_next, 32'h0000_0000);

        // Reset mid-operation clears the BTB
        rst_n = 1'b0;
        settle();
        check("midrst_next", addr_next, 32'h0040_0000);
        step();
        rst_n = 1'b1;
        check("midrst_curr", addr_curr, 32'h0040_0000);
        go_to(32'h0040_0010);
        check("midrst_btb_cleared", {31'd0, pred_taken}, 32'd0);

`ifdef MIPS_DATAPATH_PC_PREDICT_RAS_EN
        calls[0] = 32'h0040_0404;
        calls[1] = 32'h0040_0408;
        calls[2] = 32'h0040_0414;
        calls[3] = 32'h0040_0418;
        calls[4] = 32'h0040_0424;
        pops[0]  = 32'h0040_042C;
        pops[1]  = 32'h0040_0420;
        pops[2]  = 32'h0040_041C;
        pops[3]  = 32'h0040_0410;
        pops[4]  = 32'h0040_0500;
        stall = 1'b1;
        train(32'h0040_0020, 1'b1, 32'h0040_0300, KindCall);
        train(32'h0040_0300, 1'b1, 32'h0040_0500, KindReturn);
        for (int i = 0; i < 5; i++) train(calls[i], 1'b1, 32'h0040_0300, KindCall);
        stall = 1'b0;

        go_to(32'h0040_0020);
        check("ras_call_next", addr_next, 32'h0040_0300);
        step();
        check("ras_ret_target", pred_target, 32'h0040_0028);
        check("ras_ret_next", addr_next, 32'h0040_0028);
        step();

        // Five nested calls into a depth-4 stack
        for (int i = 0; i < 5; i++) begin
            redirect      = 1'b1;
            redirect_addr = calls[i];
            step();
            redirect = 1'b0;
            step();
        end
        settle();
        for (int i = 0; i < 5; i++) begin
            check("ras_nested_pop", pred_target, pops[i]);
            step();
            go_to(32'h0040_0300);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
